regfile_arb: RTL and testbench

REGFILE_ARB -- requirements
Module: regfile_arb

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 29 ++
 rtl/regfile_arb.sv | 165 ++++++++++++++++
 tb/tb_regfile_arb.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, widths and helpers for the register-file arbiter
package regfile_pkg;

    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 8;
    localparam int N_REQ   = 2;
    localparam int N_ENTRY = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // One-hot cell enable for an entry address
    function automatic logic [N_ENTRY-1:0] onehot_addr(input logic [ADDR_W-1:0] a);
        logic [N_ENTRY-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with optional lock-owner priority
module rr_arb2
    import regfile_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic             last_i,
    input  logic             lock_vld_i,
    input  logic             lock_own_i,
    output logic [N_REQ-1:0] gnt_o
);

    // Lone requester always wins; on a tie the lock owner wins, else the one not last granted
    always_comb begin
        gnt_o = '0;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11: begin
                if (lock_vld_i) begin
                    gnt_o = lock_own_i ? 2'b10 : 2'b01;
                end else begin
                    gnt_o = last_i ? 2'b01 : 2'b10;
                end
            end
            default: gnt_o = '0;
        endcase
    end

endmodule

// File: rtl/regfile_arb.sv
// rtl/regfile_arb.sv - two-requester register-file access arbiter; REGFILE_ARB_LOCK_EN adds requester locking
module regfile_arb
    import regfile_pkg::*;
(
    input  logic                CLK_i,
    input  logic                RES_i,
    input  logic [N_REQ-1:0]    REQ_i,
    input  logic [N_REQ-1:0]    WE_i,
    input  logic [ADDR_W-1:0]   ADDR0_i,
    input  logic [ADDR_W-1:0]   ADDR1_i,
    input  logic [DATA_W-1:0]   WDATA0_i,
    input  logic [DATA_W-1:0]   WDATA1_i,
`ifdef REGFILE_ARB_LOCK_EN
    input  logic [N_REQ-1:0]    LOCK_i,
`endif
    output logic [N_REQ-1:0]    GNT_o,
    output logic [N_REQ-1:0]    RVALID_o,
    output logic [DATA_W-1:0]   RDATA_o,
    output logic [N_ENTRY-1:0]  RF_EN_o,
    output logic [DATA_W-1:0]   RF_WDATA_o,
    output logic [ADDR_W-1:0]   RF_RSEL_o,
    input  logic [DATA_W-1:0]   RF_RDATA_i,
    output logic                BUSY_o
);

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                last_q, last_d;

    logic [N_REQ-1:0]    arb_gnt;
    logic                grant_any;
    logic                gidx;
    logic                lock_eff;
    logic                lock_own;

    // Arbitration only happens in IDLE and never while reset is held
    assign grant_any = (state_q == IDLE) && (|REQ_i) && !RES_i;
    assign gidx      = arb_gnt[1];

`ifdef REGFILE_ARB_LOCK_EN
    logic lock_vld_q, lock_vld_d;
    logic lock_own_q, lock_own_d;

    // Owner priority applies only while the owner still asserts its lock
    assign lock_eff = lock_vld_q && LOCK_i[lock_own_q];
    assign lock_own = lock_own_q;

    // Take ownership on a locked grant; drop it on any grant once the owner releases
    always_comb begin
        lock_vld_d = lock_vld_q;
        lock_own_d = lock_own_q;
        if (grant_any) begin
            if (LOCK_i[gidx]) begin
                lock_vld_d = 1'b1;
                lock_own_d = gidx;
            end else if (lock_vld_q && !LOCK_i[lock_own_q]) begin
                lock_vld_d = 1'b0;
            end
        end
    end

    // Lock owner registers
    always_ff @(posedge CLK_i) begin
        if (RES_i) begin
            lock_vld_q <= 1'b0;
            lock_own_q <= 1'b0;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
        end
    end
`else
    assign lock_eff = 1'b0;
    assign lock_own = 1'b0;
`endif

    rr_arb2 u_arb (
        .req_i      (REQ_i),
        .last_i     (last_q),
        .lock_vld_i (lock_eff),
        .lock_own_i (lock_own),
        .gnt_o      (arb_gnt)
    );

    // Next state, latched operation and registered-read capture
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    owner_d = gidx;
                    last_d  = gidx;
                    we_d    = WE_i[gidx];
                    addr_d  = gidx ? ADDR1_i : ADDR0_i;
                    wdata_d = gidx ? WDATA1_i : WDATA0_i;
                    state_d = WE_i[gidx] ? WRITE : READ;
                end
            end
            WRITE: state_d = IDLE;
            READ: begin
                rdata_d = RF_RDATA_i;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge CLK_i) begin
        if (RES_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            last_q  <= last_d;
        end
    end

    // Per-state outputs; reset forces every strobe low, including an in-flight write
    always_comb begin
        GNT_o      = '0;
        RVALID_o   = '0;
        RF_EN_o    = '0;
        RF_WDATA_o = '0;
        RF_RSEL_o  = '0;
        BUSY_o     = 1'b0;
        if (!RES_i) begin
            BUSY_o = (state_q != IDLE);
            case (state_q)
                IDLE:  GNT_o = grant_any ? arb_gnt : '0;
                WRITE: begin
                    RF_EN_o    = onehot_addr(addr_q);
                    RF_WDATA_o = wdata_q;
                end
                READ:  RF_RSEL_o = addr_q;
                RESP:  RVALID_o[owner_q] = 1'b1;
                default: ;
            endcase
        end
    end

    assign RDATA_o = rdata_q;

endmodule

// File: tb/tb_regfile_arb.sv
// tb/tb_regfile_arb.sv - directed self-checking bench for regfile_arb with a behavioural 8x8 register file
module tb_regfile_arb;

    logic        clk = 1'b0;
    logic        res;
    logic [1:0]  req, we;
    logic [2:0]  addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic [1:0]  lock;
    logic [1:0]  gnt, rvalid;
    logic [7:0]  rdata, rf_en, rf_wdata, rf_rdata;
    logic [2:0]  rf_rsel;
    logic        busy;
    logic        tb_init;
    logic [7:0]  rf [8];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_r0, n_r1;
    logic [1:0]  g;

    always #5 clk = ~clk;

    regfile_arb dut (
        .CLK_i      (clk),
        .RES_i      (res),
        .REQ_i      (req),
        .WE_i       (we),
        .ADDR0_i    (addr0),
        .ADDR1_i    (addr1),
        .WDATA0_i   (wdata0),
        .WDATA1_i   (wdata1),
`ifdef REGFILE_ARB_LOCK_EN
        .LOCK_i     (lock),
`endif
        .GNT_o      (gnt),
        .RVALID_o   (rvalid),
        .RDATA_o    (rdata),
        .RF_EN_o    (rf_en),
        .RF_WDATA_o (rf_wdata),
        .RF_RSEL_o  (rf_rsel),
        .RF_RDATA_i (rf_rdata),
        .BUSY_o     (busy)
    );

    // Register cells: preset while tb_init, otherwise written by the one-hot enables
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (tb_init) rf[i] <= 8'h40 + 8'(i);
            else if (rf_en[i]) rf[i] <= rf_wdata;
        end
    end

    assign rf_rdata = rf[rf_rsel];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a non-zero grant, sampling on falling edges
    task automatic wait_gnt(output logic [1:0] gv);
        gv = 2'b00;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                gv = gnt;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res = 1'b1; tb_init = 1'b1; req = 2'b11; we = 2'b11; lock = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        step(); step();
        @(negedge clk);
        check("rst_gnt", gnt, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_rf_en", rf_en, 8'h00);
        check("rst_rsel", rf_rsel, 3'd0);
        check("rst_wdata", rf_wdata, 8'h00);
        check("rst_rvalid", rvalid, 2'b00);
        check("rst_rdata", rdata, 8'h00);

        // Simultaneous writes to entry 3: r0 wins first tie after reset
        step();
        res = 1'b0; tb_init = 1'b0;
        req = 2'b11; we = 2'b11; addr0 = 3'd3; wdata0 = 8'hA5; addr1 = 3'd3; wdata1 = 8'h5A;
        @(negedge clk); check("tie_gnt1", gnt, 2'b01);
        step(); req = 2'b10;
        @(negedge clk);
        check("tie_wr1_gnt", gnt, 2'b00);
        check("tie_wr1_en", rf_en, 8'h08);
        check("tie_wr1_data", rf_wdata, 8'hA5);
        check("tie_wr1_busy", busy, 1'b1);
        step();
        @(negedge clk); check("tie_gnt2", gnt, 2'b10);
        step(); req = 2'b00;
        @(negedge clk);
        check("tie_wr2_en", rf_en, 8'h08);
        check("tie_wr2_data", rf_wdata, 8'h5A);
        step();
        @(negedge clk);
        check("tie_entry3", rf[3], 8'h5A);
        check("tie_idle_busy", busy, 1'b0);

        // r0 write entry 7
        step();
        req = 2'b01; we = 2'b01; addr0 = 3'd7; wdata0 = 8'h3C;
        @(negedge clk);
        check("w7_gnt", gnt, 2'b01);
        check("w7_busy_t", busy, 1'b0);
        step(); req = 2'b00;
        @(negedge clk);
        check("w7_en", rf_en, 8'h80);
        check("w7_data", rf_wdata, 8'h3C);
        check("w7_busy_t1", busy, 1'b1);
        step();
        @(negedge clk);
        check("w7_en_t2", rf_en, 8'h00);
        check("w7_busy_t2", busy, 1'b0);

        // r1 read entry 7
        step();
        req = 2'b10; we = 2'b00; addr1 = 3'd7;
        @(negedge clk); check("r7_gnt", gnt, 2'b10);
        step(); req = 2'b00;
        @(negedge clk);
        check("r7_rsel", rf_rsel, 3'd7);
        check("r7_rvalid_t1", rvalid, 2'b00);
        check("r7_busy_t1", busy, 1'b1);
        check("r7_en_t1", rf_en, 8'h00);
        step();
        @(negedge clk);
        check("r7_rvalid", rvalid, 2'b10);
        check("r7_rdata", rdata, 8'h3C);
        check("r7_rsel_t2", rf_rsel, 3'd0);
        step();
        @(negedge clk);
        check("r7_rvalid_t3", rvalid, 2'b00);
        check("r7_rdata_hold", rdata, 8'h3C);
        check("r7_busy_t3", busy, 1'b0);

        // Continuous contention: six alternating grants
        step();
        req = 2'b11; we = 2'b11; addr0 = 3'd0; wdata0 = 8'h11; addr1 = 3'd1; wdata1 = 8'h22;
        n_r0 = 0; n_r1 = 0;
        for (int k = 0; k < 6; k++) begin
            wait_gnt(g);
            check($sformatf("rr_gnt%0d", k), g, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (g == 2'b01) n_r0++;
            if (g == 2'b10) n_r1++;
            step();
        end
        req = 2'b00;
        check("rr_count_r0", n_r0, 3);
        check("rr_count_r1", n_r1, 3);
        step();
        @(negedge clk);
        check("rr_entry0", rf[0], 8'h11);
        check("rr_entry1", rf[1], 8'h22);

        // Reset during a write to entry 2
        step();
        req = 2'b01; we = 2'b01; addr0 = 3'd2; wdata0 = 8'hFF;
        @(negedge clk); check("rw_gnt", gnt, 2'b01);
        step(); req = 2'b00; res = 1'b1;
        @(negedge clk);
        check("rw_en", rf_en, 8'h00);
        check("rw_wdata", rf_wdata, 8'h00);
        check("rw_busy", busy, 1'b0);
        step(); res = 1'b0;
        @(negedge clk);
        check("rw_entry2", rf[2], 8'h42);
        check("rw_post_busy", busy, 1'b0);
        check("rw_post_en", rf_en, 8'h00);
        check("rw_post_gnt", gnt, 2'b00);
        check("rw_post_rvalid", rvalid, 2'b00);
        check("rw_post_rdata", rdata, 8'h00);

`ifdef REGFILE_ARB_LOCK_EN
        // r0 locks and keeps winning ties until it releases
        step();
        req = 2'b11; we = 2'b11; lock = 2'b01;
        addr0 = 3'd4; wdata0 = 8'h44; addr1 = 3'd5; wdata1 = 8'h55;
        for (int k = 0; k < 3; k++) begin
            wait_gnt(g);
            check($sformatf("lock_gnt%0d", k), g, 2'b01);
            step();
        end
        lock = 2'b00;
        wait_gnt(g);
        check("lock_release_gnt", g, 2'b10);
        step();
        req = 2'b00;
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
